// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encoding, defaults and sizing helper for the bus arbiter.
package bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, TURN} state_e;
  localparam int BUS_W = 4;
  localparam int NREQ_DEF = 4;
  localparam int SETTLE_DEF = 1;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, searching upward from ptr+1 modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);
  assign valid = |req;
  // Scanning from the farthest candidate down lets the nearest set bit win last.
  always_comb begin
    winner = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) winner = IW'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of a shared tristate bus with settle delay and turnaround gap.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int SETTLE = SETTLE_DEF,
  localparam int IW = clog2(NREQ)
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic [NREQ-1:0] Req,
  output logic [NREQ-1:0] Enable,
  output logic            LoadOut,
  output logic [NREQ-1:0] Ack,
  output logic [IW-1:0]   GrantId,
  output logic            Busy
);
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, pick_w;
  logic [NREQ-1:0] en_q, en_d, ack_q, ack_d;
  logic load_q, load_d, busy_q, busy_d, pick_v;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req(Req),
    .ptr(ptr_q),
    .winner(pick_w),
    .valid(pick_v)
  );
  // Leaving TURN arbitrates directly, so back-to-back transfers take SETTLE+2 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    unique case (state_q)
      IDLE, TURN: begin
        state_d = pick_v ? DRIVE : IDLE;
        gid_d = pick_v ? pick_w : gid_q;
        cnt_d = pick_v ? 3'(SETTLE) : cnt_q;
      end
      DRIVE: begin
        state_d = !Req[gid_q] ? TURN : (cnt_q == 3'd1) ? LOAD : DRIVE;
        cnt_d = cnt_q - 3'd1;
      end
      LOAD: begin
        state_d = TURN;
        ptr_d = gid_q;
      end
    endcase
    en_d = (state_d == DRIVE || state_d == LOAD) ? NREQ'(1) << gid_d : '0;
    load_d = state_d == LOAD;
    ack_d = load_d ? en_d : '0;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= IW'(NREQ - 1);
      gid_q <= '0;
      en_q <= '0;
      ack_q <= '0;
      load_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      en_q <= en_d;
      ack_q <= ack_d;
      load_q <= load_d;
      busy_q <= busy_d;
    end
  end
  assign Enable = en_q;
  assign LoadOut = load_q;
  assign Ack = ack_q;
  assign GrantId = gid_q;
  assign Busy = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: two arbiters (SETTLE=1 and SETTLE=3) checked every cycle against a transfer-age model.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] en [2];
  logic [3:0] ack [2];
  logic ld [2];
  logic busy [2];
  logic [1:0] gid [2];
  int tests = 0;
  int fails = 0;
  int sv [2] = '{1, 3};
  int m_k [2];
  int m_own [2];
  int m_ptr [2];
  bit m_act [2];
  bus_arbiter #(.NREQ(4), .SETTLE(1)) u1 (
    .Clock(clk), .ResetN(rst_n), .Req(req), .Enable(en[0]), .LoadOut(ld[0]),
    .Ack(ack[0]), .GrantId(gid[0]), .Busy(busy[0])
  );
  bus_arbiter #(.NREQ(4), .SETTLE(3)) u3 (
    .Clock(clk), .ResetN(rst_n), .Req(req), .Enable(en[1]), .LoadOut(ld[1]),
    .Ack(ack[1]), .GrantId(gid[1]), .Busy(busy[1])
  );
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[dut%0d]: got %0h expected %0h", tag, i, obs, exp);
    end
  endtask
  function automatic int rr(input logic [3:0] r, input int p);
    for (int j = 1; j <= 4; j++) if (r[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0;
      m_k[i] = 0;
      m_own[i] = 0;
      m_ptr[i] = 3;
    end
  endtask
  // m_k counts edges since the grant: 0..S-1 settling, S loading, S+1 turnaround.
  task automatic model_edge(input int i);
    int s, w;
    s = sv[i];
    if (!m_act[i] || m_k[i] == s + 1) begin
      w = rr(req, m_ptr[i]);
      m_act[i] = w >= 0;
      if (w >= 0) begin
        m_own[i] = w;
        m_k[i] = 0;
      end
    end else if (m_k[i] == s) begin
      m_ptr[i] = m_own[i];
      m_k[i] = s + 1;
    end else if (!req[m_own[i]]) m_k[i] = s + 1;
    else m_k[i]++;
  endtask
  task automatic chk(input int i);
    logic [3:0] ee;
    logic el;
    ee = (m_act[i] && m_k[i] <= sv[i]) ? 4'(1 << m_own[i]) : 4'b0;
    el = m_act[i] && m_k[i] == sv[i];
    cmp("enable", i, 8'(en[i]), 8'(ee));
    cmp("loadout", i, 8'(ld[i]), 8'(el));
    cmp("ack", i, 8'(ack[i]), 8'(el ? ee : 4'b0));
    cmp("busy", i, 8'(busy[i]), 8'(m_act[i]));
    cmp("grantid", i, 8'(gid[i]), 8'(m_own[i]));
    cmp("onehot", i, 8'($countones(en[i]) <= 1), 8'd1);
  endtask
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) chk(i);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) chk(i);
    #3;
    rst_n = 1'b1;
  endtask
  initial begin
    int n, nl;
    bit got;
    logic [3:0] prev;
    int ord [5] = '{0, 1, 2, 3, 0};
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    req = 4'b0100;
    step();
    cmp("single_en", 0, 8'(en[0]), 8'h04);
    step();
    cmp("single_ld", 0, 8'(ld[0]), 8'h01);
    cmp("single_ack", 0, 8'(ack[0]), 8'h04);
    req = 4'b0;
    step();
    cmp("single_drop", 0, 8'(en[0]), 8'h00);
    cmp("single_gid", 0, 8'(gid[0]), 8'h02);
    do_reset();
    req = 4'b1111;
    n = 0;
    repeat (15) begin
      step();
      if (ld[0]) begin
        if (n < 5) cmp("order", 0, 8'(gid[0]), 8'(ord[n]));
        n++;
      end
    end
    cmp("loads", 0, 8'(n), 8'd5);
    req = 4'b0010;
    prev = en[0];
    repeat (12) begin
      step();
      if (prev[1] && !en[0][1]) cmp("gap", 0, 8'(en[0]), 8'h00);
      if (ack[0][1]) req = 4'b0100;
      prev = en[0];
    end
    req = 4'b0;
    repeat (6) step();
    do_reset();
    req = 4'b1000;
    step();
    cmp("abort_drive", 1, 8'(en[1]), 8'h08);
    req = 4'b0;
    step();
    cmp("abort_en", 1, 8'(en[1]), 8'h00);
    cmp("abort_ld", 1, 8'(ld[1]), 8'h00);
    req = 4'b1001;
    step();
    cmp("abort_next", 1, 8'(gid[1]), 8'h00);
    req = 4'b0;
    repeat (8) step();
    do_reset();
    req = 4'b0100;
    step();
    step();
    cmp("mid_load", 0, 8'(ld[0]), 8'h01);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("arst_ld", 0, 8'(ld[0]), 8'h00);
    cmp("arst_en", 0, 8'(en[0]), 8'h00);
    cmp("arst_ack", 0, 8'(ack[0]), 8'h00);
    for (int i = 0; i < 2; i++) chk(i);
    rst_n = 1'b1;
    req = 4'b1010;
    step();
    cmp("arst_first", 0, 8'(gid[0]), 8'h01);
    req = 4'b0;
    repeat (8) step();
    do_reset();
    req = 4'b0001;
    repeat (3) step();
    req = 4'b0101;
    nl = 0;
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if (ld[0]) nl++;
      if (ack[0][2]) got = 1;
    end
    cmp("fair", 0, 8'(got && nl <= 2), 8'd1);
    req = 4'b0;
    repeat (8) step();
    repeat (600) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      step();
    end
    req = 4'b0;
    repeat (8) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin controller that shares the 4-bit tristate bus B[3:0] among NREQ InRegister-style input registers. It drives each register's EnableIn so at most one source drives the bus at any time. It also pulses a load strobe to the destination register once the bus has settled, and inserts a dead cycle between owners so two bufif1 drivers never overlap.

## Interface

Parameters:
- NREQ, 4: number of requesting source registers (2..8).
- SETTLE, 1: cycles Enable is held before LoadOut fires (1..7).

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- ResetN  input  1  asynchronous, active-low reset; clears all state immediately.
- Req  input  NREQ  Req[i]=1 means source i wants to place its data on the bus.
- Enable  output  NREQ  one-hot or zero; Enable[i] ties to EnableIn of source i.
- LoadOut  output  1  one-cycle strobe; the destination captures B[3:0] on the next edge.
- Ack  output  NREQ  one-cycle pulse to source i, coincident with LoadOut.
- GrantId  output  clog2(NREQ)  index of the current or last owner.
- Busy  output  1  high in every state except IDLE.

## Operation

- FSM states: IDLE, DRIVE, LOAD, TURN.
- IDLE:
  - If any Req bit is set, pick the winner by round-robin, starting at Ptr+1 modulo NREQ.
  - Set GrantId to the winner, load the settle counter with SETTLE, and go to DRIVE.
- DRIVE:
  - Enable[GrantId]=1 and the counter decrements each cycle.
  - At zero, go to LOAD.
  - If Req[GrantId] drops in DRIVE, abort: go to TURN with no LoadOut and no Ack.
- LOAD:
  - Enable[GrantId] stays 1; LoadOut=1 and Ack[GrantId]=1 for exactly one cycle.
  - Update Ptr to GrantId, then go to TURN.
  - Req is not sampled in LOAD, so a withdrawal here does not cancel the transfer.
- TURN:
  - Enable is all-zero for one cycle (bus floats / turnaround), then go to IDLE.
- Pointer rules:
  - Ptr resets to NREQ-1, so requester 0 has first priority after reset.
  - Ptr updates only on a completed transfer; an abort leaves it unchanged.
- A requester that keeps Req high after Ack re-enters arbitration at lowest priority.
- Outputs Enable, LoadOut, Ack and Busy are registered (decoded from registered state), so they are glitch-free.
- Invariants:
  - popcount(Enable) ≤ 1 in every cycle.
  - LoadOut is high only if exactly one Enable bit is high.
  - Ack is one-hot or zero, and its bit equals the set Enable bit.
- Reset values:
  - Enable=0, LoadOut=0, Ack=0, Busy=0, GrantId=0.
  - State=IDLE, Ptr=NREQ-1.

## Timing

- Cycle numbering: Req is first sampled high in IDLE at edge 0.
- Edge 0: arbitration decision; Enable[i] and Busy rise after edge 0.
- Edge SETTLE: LoadOut and Ack rise and are valid for one cycle.
- Edge SETTLE+1: the destination captures the bus; Enable drops; TURN is entered.
- Edge SETTLE+2: IDLE is entered; the next arbitration happens at edge SETTLE+2.
- Result: one transfer per SETTLE+2 cycles under continuous requests (3 cycles with default SETTLE=1).
- Req changes in DRIVE, LOAD or TURN do not affect GrantId; new requesters wait for IDLE.
- Simultaneous requests are resolved in one cycle by round-robin order; there is no starvation, and worst-case wait is (NREQ-1)·(SETTLE+2) cycles after the current transfer.
- ResetN low mid-transfer:
  - Enable, LoadOut and Ack go to 0 asynchronously, without waiting for Clock.
  - The pending transfer is lost and produces no Ack.
  - After release, operation restarts from IDLE with Ptr=NREQ-1.

## Structure

- Shared package holds:
  - state enum {IDLE, DRIVE, LOAD, TURN};
  - constants BUS_W=4, NREQ_DEF=4, SETTLE_DEF=1;
  - function clog2.
- One sub-module, rr_pick: a combinational round-robin selector with inputs Req and Ptr, and outputs Winner index and Valid.
- Top level holds the FSM, settle counter, Ptr and output registers.

## Test plan

- Reset then single request: Req=4'b0100 → Enable=4'b0100 one cycle after edge 0; LoadOut and Ack=4'b0100 at edge 1; Enable=0 at edge 2; GrantId=2.
- All requesting continuously: Req=4'b1111 held → grant order 0,1,2,3,0; one LoadOut every 3 cycles; popcount(Enable) ≤ 1 checked every cycle.
- Turnaround gap: back-to-back Req[1], Req[2] → at least one cycle with Enable=0 between Enable[1] falling and Enable[2] rising.
- Abort in DRIVE (SETTLE=3): Req[3] dropped at edge 1 → Enable[3] falls, no LoadOut or Ack, Ptr unchanged; a following Req=4'b1001 grants 0.
- Asynchronous reset mid-LOAD: ResetN low between edges while LoadOut=1 → all outputs 0 immediately; after release, Req=4'b1010 grants 1 first.
- Fairness: Req[0] held permanently, Req[2] asserted once → Req[2] granted within 2 transfers.
